// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - SRAM-like request/response port bundle
//
// Purpose: one SRAM-like port: request fields travel master -> slave,
//          accept/response signals travel slave -> master.
// Ports (signals):
//   req, wr, size[1:0], addr[31:0], wstrb[3:0], wdata[31:0]  master -> slave
//   addr_ok, data_ok, rdata[31:0]                            slave -> master
// Modports:
//   master : the side issuing requests
//   slave  : the side accepting requests and returning responses

interface sram_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-master SRAM arbiter with in-order owner FIFO
//
// Purpose: shares one downstream SRAM-like port between the instruction
//          fetch requester and the data requester. Data wins in IDLE; the
//          chosen source stays locked while it waits for addr_ok. Each
//          accepted request's owner is queued so in-order responses can be
//          steered back to the right requester.
// Parameters:
//   OUTSTANDING  maximum accepted-but-unreturned requests (>= 1)
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset
//   inst_sram  slave port facing the instruction-fetch requester
//   data_sram  slave port facing the data requester
//   mem        master port facing the downstream bridge

module sram_arbiter #(
  parameter int OUTSTANDING = 2
) (
  input  logic          clk,
  input  logic          reset,
  sram_arbiter_if.slave  inst_sram,
  sram_arbiter_if.slave  data_sram,
  sram_arbiter_if.master mem
);

  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(OUTSTANDING + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OUTSTANDING);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_I = 2'd1,
    LOCK_D = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                   sel_data;
  logic                   sel_req;
  logic                   issue;
  logic                   accept;
  logic                   full;
  logic                   empty;
  logic                   pop;
  logic                   head;
  logic [OUTSTANDING-1:0] owner_q;
  logic [PTR_W-1:0]       wr_ptr_q;
  logic [PTR_W-1:0]       rd_ptr_q;
  logic [CNT_W-1:0]       count_q;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    ptr_next = (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_FULL);
  assign head  = owner_q[rd_ptr_q];

  // Source selection and lock FSM next state.
  always_comb begin
    sel_data = 1'b0;
    state_d  = state_q;

    case (state_q)
      LOCK_D:  sel_data = 1'b1;
      LOCK_I:  sel_data = 1'b0;
      default: sel_data = data_sram.req;
    endcase

    sel_req = sel_data ? data_sram.req : inst_sram.req;
    // A full owner FIFO blocks issue even when a pop happens this cycle,
    // so the slot being freed is never reused combinationally.
    issue   = sel_req && !full && !reset;
    accept  = issue && mem.addr_ok;

    case (state_q)
      IDLE: begin
        if (issue && !mem.addr_ok) begin
          state_d = sel_data ? LOCK_D : LOCK_I;
        end
      end
      LOCK_I, LOCK_D: begin
        if (accept) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Downstream request mux; fields read as zero when nothing is requested.
  always_comb begin
    mem.req   = issue;
    mem.wr    = 1'b0;
    mem.size  = 2'd0;
    mem.addr  = 32'd0;
    mem.wstrb = 4'd0;
    mem.wdata = 32'd0;
    if (sel_req) begin
      if (sel_data) begin
        mem.wr    = data_sram.wr;
        mem.size  = data_sram.size;
        mem.addr  = data_sram.addr;
        mem.wstrb = data_sram.wstrb;
        mem.wdata = data_sram.wdata;
      end else begin
        mem.wr    = inst_sram.wr;
        mem.size  = inst_sram.size;
        mem.addr  = inst_sram.addr;
        mem.wstrb = inst_sram.wstrb;
        mem.wdata = inst_sram.wdata;
      end
    end
  end

  // Responses with an empty FIFO are a downstream protocol error and are dropped.
  assign pop = mem.data_ok && !empty && !reset;

  assign inst_sram.addr_ok = accept && !sel_data;
  assign data_sram.addr_ok = accept && sel_data;
  assign inst_sram.data_ok = pop && !head;
  assign data_sram.data_ok = pop && head;
  assign inst_sram.rdata   = mem.rdata;
  assign data_sram.rdata   = mem.rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q[wr_ptr_q] <= sel_data;
        wr_ptr_q          <= ptr_next(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_next(rd_ptr_q);
      end
      case ({accept, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter

module tb_sram_arbiter;
  localparam int OUTSTANDING = 2;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sram_arbiter_if inst_bus ();
  sram_arbiter_if data_bus ();
  sram_arbiter_if mem_bus ();

  sram_arbiter #(.OUTSTANDING(OUTSTANDING)) dut (
    .clk       (clk),
    .reset     (reset),
    .inst_sram (inst_bus),
    .data_sram (data_bus),
    .mem       (mem_bus)
  );

  // Reference model state: owner queue of accepted requests (0=inst, 1=data)
  // and the source a stalled request is pinned to (-1 when none).
  int owners[$];
  int lock_src = -1;

  // {inst addr_ok, data addr_ok, inst data_ok, data data_ok}
  function automatic logic [3:0] oks();
    oks = {inst_bus.addr_ok, data_bus.addr_ok, inst_bus.data_ok, data_bus.data_ok};
  endfunction

  function automatic logic [71:0] req_vec();
    req_vec = {mem_bus.req, mem_bus.wr, mem_bus.size, mem_bus.addr, mem_bus.wstrb, mem_bus.wdata};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inst_bus.req = 0; inst_bus.wr = 0; inst_bus.size = 0; inst_bus.addr = 0;
    inst_bus.wstrb = 0; inst_bus.wdata = 0;
    data_bus.req = 0; data_bus.wr = 0; data_bus.size = 0; data_bus.addr = 0;
    data_bus.wstrb = 0; data_bus.wdata = 0;
    mem_bus.addr_ok = 0; mem_bus.data_ok = 0; mem_bus.rdata = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    inst_bus.req = 1; data_bus.req = 1; mem_bus.addr_ok = 1; mem_bus.data_ok = 1;
    @(negedge clk);
    checks++;
    if (mem_bus.req !== 1'b0) begin
      failures++; $display("FAIL reset_mem_req actual=%0h expected=0", mem_bus.req);
    end
    checks++;
    if (oks() !== 4'b0000) begin
      failures++; $display("FAIL reset_oks actual=%b expected=0000", oks());
    end
    tick();
    reset = 0;
    clear_inputs();
    @(negedge clk);
    checks++;
    if (req_vec() !== 72'd0 || oks() !== 4'b0000) begin
      failures++; $display("FAIL post_reset_idle actual=%h/%b expected=0/0000", req_vec(), oks());
    end
    tick();
  endtask

  task automatic test_single_inst_read();
    inst_bus.req = 1; inst_bus.addr = 32'h1c000000; inst_bus.size = 2; mem_bus.addr_ok = 1;
    @(negedge clk);
    checks++;
    if (mem_bus.req !== 1'b1 || mem_bus.addr !== 32'h1c000000 || oks() !== 4'b1000) begin
      failures++;
      $display("FAIL single_accept actual=req%0h addr%h oks%b expected=req1 addr1c000000 oks1000",
               mem_bus.req, mem_bus.addr, oks());
    end
    tick();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (req_vec() !== 72'd0 || oks() !== 4'b0000) begin
      failures++; $display("FAIL single_gap actual=%h/%b expected=0/0000", req_vec(), oks());
    end
    tick();
    mem_bus.data_ok = 1; mem_bus.rdata = 32'h02800413;
    @(negedge clk);
    checks++;
    if (oks() !== 4'b0010 || inst_bus.rdata !== 32'h02800413) begin
      failures++; $display("FAIL single_resp actual=oks%b rdata%h expected=oks0010 rdata02800413",
                           oks(), inst_bus.rdata);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_priority();
    inst_bus.req = 1; inst_bus.addr = 32'h1c000010; inst_bus.size = 2;
    data_bus.req = 1; data_bus.addr = 32'h1c008000; data_bus.size = 2;
    mem_bus.addr_ok = 1;
    @(negedge clk);
    checks++;
    if (oks() !== 4'b0100 || mem_bus.addr !== 32'h1c008000) begin
      failures++; $display("FAIL prio_data_first actual=oks%b addr%h expected=oks0100 addr1c008000",
                           oks(), mem_bus.addr);
    end
    tick();
    data_bus.req = 0;
    @(negedge clk);
    checks++;
    if (oks() !== 4'b1000 || mem_bus.addr !== 32'h1c000010) begin
      failures++; $display("FAIL prio_inst_second actual=oks%b addr%h expected=oks1000 addr1c000010",
                           oks(), mem_bus.addr);
    end
    tick();
    clear_inputs();
    mem_bus.data_ok = 1; mem_bus.rdata = 32'h0000AAAA;
    @(negedge clk);
    checks++;
    if (oks() !== 4'b0001 || data_bus.rdata !== 32'h0000AAAA) begin
      failures++; $display("FAIL prio_resp1 actual=oks%b rdata%h expected=oks0001 rdata0000aaaa",
                           oks(), data_bus.rdata);
    end
    tick();
    mem_bus.rdata = 32'h0000BBBB;
    @(negedge clk);
    checks++;
    if (oks() !== 4'b0010 || inst_bus.rdata !== 32'h0000BBBB) begin
      failures++; $display("FAIL prio_resp2 actual=oks%b rdata%h expected=oks0010 rdata0000bbbb",
                           oks(), inst_bus.rdata);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_lock();
    inst_bus.req = 1; inst_bus.addr = 32'h1c000040; inst_bus.size = 2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (mem_bus.req !== 1'b1 || mem_bus.addr !== 32'h1c000040 || oks() !== 4'b0000) begin
        failures++; $display("FAIL lock_wait%0d actual=req%0h addr%h oks%b expected=req1 addr1c000040 oks0000",
                             i, mem_bus.req, mem_bus.addr, oks());
      end
      tick();
    end
    data_bus.req = 1; data_bus.addr = 32'h1c008010; data_bus.size = 2; data_bus.wr = 1;
    @(negedge clk);
    checks++;
    if (mem_bus.addr !== 32'h1c000040 || mem_bus.wr !== 1'b0 || oks() !== 4'b0000) begin
      failures++; $display("FAIL lock_hold actual=addr%h wr%0h oks%b expected=addr1c000040 wr0 oks0000",
                           mem_bus.addr, mem_bus.wr, oks());
    end
    tick();
    mem_bus.addr_ok = 1;
    @(negedge clk);
    checks++;
    if (oks() !== 4'b1000 || mem_bus.addr !== 32'h1c000040) begin
      failures++; $display("FAIL lock_release actual=oks%b addr%h expected=oks1000 addr1c000040",
                           oks(), mem_bus.addr);
    end
    tick();
    inst_bus.req = 0;
    @(negedge clk);
    checks++;
    if (oks() !== 4'b0100 || mem_bus.addr !== 32'h1c008010) begin
      failures++; $display("FAIL lock_then_data actual=oks%b addr%h expected=oks0100 addr1c008010",
                           oks(), mem_bus.addr);
    end
    tick();
    clear_inputs();
    mem_bus.data_ok = 1;
    @(negedge clk);
    checks++;
    if (oks() !== 4'b0010) begin
      failures++; $display("FAIL lock_resp_inst actual=%b expected=0010", oks());
    end
    tick();
    @(negedge clk);
    checks++;
    if (oks() !== 4'b0001) begin
      failures++; $display("FAIL lock_resp_data actual=%b expected=0001", oks());
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    inst_bus.req = 1; inst_bus.size = 2; mem_bus.addr_ok = 1;
    for (int i = 0; i < 2; i++) begin
      inst_bus.addr = 32'h1c000100 + 32'(i * 4);
      @(negedge clk);
      checks++;
      if (oks() !== 4'b1000) begin
        failures++; $display("FAIL b2b_accept%0d actual=%b expected=1000", i, oks());
      end
      tick();
    end
    inst_bus.addr = 32'h1c000108;
    @(negedge clk);
    checks++;
    if (mem_bus.req !== 1'b0 || oks() !== 4'b0000) begin
      failures++; $display("FAIL b2b_full actual=req%0h oks%b expected=req0 oks0000", mem_bus.req, oks());
    end
    tick();
    mem_bus.data_ok = 1;
    @(negedge clk);
    checks++;
    if (mem_bus.req !== 1'b0 || oks() !== 4'b0010) begin
      failures++; $display("FAIL b2b_full_pop actual=req%0h oks%b expected=req0 oks0010", mem_bus.req, oks());
    end
    tick();
    mem_bus.data_ok = 0;
    @(negedge clk);
    checks++;
    if (mem_bus.req !== 1'b1 || oks() !== 4'b1000 || mem_bus.addr !== 32'h1c000108) begin
      failures++; $display("FAIL b2b_reissue actual=req%0h oks%b addr%h expected=req1 oks1000 addr1c000108",
                           mem_bus.req, oks(), mem_bus.addr);
    end
    tick();
    clear_inputs();
    mem_bus.data_ok = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (oks() !== 4'b0010) begin
        failures++; $display("FAIL b2b_drain%0d actual=%b expected=0010", i, oks());
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_write();
    data_bus.req = 1; data_bus.wr = 1; data_bus.size = 1; data_bus.addr = 32'h1c000202;
    data_bus.wstrb = 4'b0011; data_bus.wdata = 32'h12345678; mem_bus.addr_ok = 1;
    @(negedge clk);
    checks++;
    if (req_vec() !== {1'b1, 1'b1, 2'd1, 32'h1c000202, 4'b0011, 32'h12345678} || oks() !== 4'b0100) begin
      failures++; $display("FAIL write_fields actual=%h oks%b expected=%h oks0100", req_vec(), oks(),
                           {1'b1, 1'b1, 2'd1, 32'h1c000202, 4'b0011, 32'h12345678});
    end
    tick();
    clear_inputs();
    mem_bus.data_ok = 1;
    @(negedge clk);
    checks++;
    if (oks() !== 4'b0001) begin
      failures++; $display("FAIL write_done actual=%b expected=0001", oks());
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    inst_bus.req = 1; inst_bus.size = 2; inst_bus.addr = 32'h1c000300; mem_bus.addr_ok = 1;
    tick();
    tick();
    clear_inputs();
    reset = 1; mem_bus.data_ok = 1;
    @(negedge clk);
    checks++;
    if (oks() !== 4'b0000 || mem_bus.req !== 1'b0) begin
      failures++; $display("FAIL rst_mid_outputs actual=oks%b req%0h expected=oks0000 req0", oks(), mem_bus.req);
    end
    tick();
    reset = 0;
    @(negedge clk);
    checks++;
    if (oks() !== 4'b0000) begin
      failures++; $display("FAIL rst_spurious actual=%b expected=0000", oks());
    end
    tick();
    // Two fresh accepts must fit, then the third is blocked: count restarted at 0.
    clear_inputs();
    inst_bus.req = 1; inst_bus.size = 2; inst_bus.addr = 32'h1c000400; mem_bus.addr_ok = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (oks() !== ((i < 2) ? 4'b1000 : 4'b0000)) begin
        failures++; $display("FAIL rst_refill%0d actual=%b expected=%b", i, oks(), (i < 2) ? 4'b1000 : 4'b0000);
      end
      tick();
    end
    clear_inputs();
    mem_bus.data_ok = 1;
    tick();
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    logic [71:0] exp_vec;
    logic [3:0]  exp_oks;
    int          sel;
    logic        sreq, exp_req, exp_acc, do_pop;

    reset = 1;
    clear_inputs();
    tick();
    reset = 0;
    owners.delete();
    lock_src = -1;

    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      if (reset) begin
        inst_bus.req = 0;
        data_bus.req = 0;
      end else begin
        if (!inst_bus.req && $urandom_range(0, 2) == 0) begin
          inst_bus.req = 1; inst_bus.wr = 1'($urandom); inst_bus.size = 2'($urandom_range(0, 2));
          inst_bus.addr = $urandom; inst_bus.wstrb = 4'($urandom); inst_bus.wdata = $urandom;
        end
        if (!data_bus.req && $urandom_range(0, 2) == 0) begin
          data_bus.req = 1; data_bus.wr = 1'($urandom); data_bus.size = 2'($urandom_range(0, 2));
          data_bus.addr = $urandom; data_bus.wstrb = 4'($urandom); data_bus.wdata = $urandom;
        end
      end
      mem_bus.addr_ok = ($urandom_range(0, 3) != 0);
      mem_bus.data_ok = (owners.size() > 0) && ($urandom_range(0, 1) == 1);
      mem_bus.rdata   = $urandom;
      @(negedge clk);

      sel     = (lock_src >= 0) ? lock_src : (data_bus.req ? 1 : 0);
      sreq    = (sel == 1) ? data_bus.req : inst_bus.req;
      exp_req = sreq && (owners.size() < OUTSTANDING) && !reset;
      exp_acc = exp_req && mem_bus.addr_ok;
      do_pop  = mem_bus.data_ok && (owners.size() > 0) && !reset;
      exp_vec = 72'd0;
      if (sreq) begin
        if (sel == 1)
          exp_vec = {1'b0, data_bus.wr, data_bus.size, data_bus.addr, data_bus.wstrb, data_bus.wdata};
        else
          exp_vec = {1'b0, inst_bus.wr, inst_bus.size, inst_bus.addr, inst_bus.wstrb, inst_bus.wdata};
      end
      exp_vec[71] = exp_req;
      exp_oks = {exp_acc && sel == 0, exp_acc && sel == 1,
                 do_pop && owners[0] == 0, do_pop && owners[0] == 1};

      checks++;
      if (req_vec() !== exp_vec) begin
        failures++; $display("FAIL rand_req%0d actual=%h expected=%h", n, req_vec(), exp_vec);
      end
      checks++;
      if (oks() !== exp_oks || inst_bus.rdata !== mem_bus.rdata || data_bus.rdata !== mem_bus.rdata) begin
        failures++; $display("FAIL rand_oks%0d actual=%b expected=%b", n, oks(), exp_oks);
      end

      if (reset) begin
        owners.delete();
        lock_src = -1;
      end else begin
        if (do_pop) void'(owners.pop_front());
        if (exp_acc) begin
          owners.push_back(sel);
          lock_src = -1;
        end else if (exp_req) begin
          lock_src = sel;
        end
      end
      tick();
      if (exp_acc && sel == 0) inst_bus.req = 0;
      if (exp_acc && sel == 1) data_bus.req = 0;
    end
    reset = 0;
    clear_inputs();
    tick();
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    test_reset();
    test_single_inst_read();
    test_priority();
    test_lock();
    test_back_to_back();
    test_write();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-master arbiter that shares one SRAM-like memory port between the instruction-fetch requester (IF stage) and the data requester (EXE issues, MEM stage consumes `data_ok`/`rdata`). It selects one request per cycle, with data priority, and locks the selection while a request waits for `addr_ok`. It records the owner of every accepted request in an in-order FIFO and steers each returning `data_ok` to that owner. It sits between the pipeline's `inst_sram_*`/`data_sram_*` ports and the downstream bridge.

## Interface
- OUTSTANDING, 2, maximum accepted-but-unreturned requests (≥1)
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- {inst,data}_sram_req  input  1  request valid, held until addr_ok
- {inst,data}_sram_wr  input  1  1=write, 0=read
- {inst,data}_sram_size  input  2  0=byte, 1=half, 2=word
- {inst,data}_sram_addr  input  32  byte address
- {inst,data}_sram_wstrb  input  4  write byte enables
- {inst,data}_sram_wdata  input  32  write data
- {inst,data}_sram_addr_ok  output  1  request accepted this cycle
- {inst,data}_sram_data_ok  output  1  read data returned / write done this cycle
- {inst,data}_sram_rdata  output  32  read data (broadcast of mem_rdata)
- mem_req, mem_wr, mem_size[1:0], mem_addr[31:0], mem_wstrb[3:0], mem_wdata[31:0]  output  request fields to downstream
- mem_addr_ok  input  1  downstream accepts request
- mem_data_ok  input  1  downstream response, strictly in acceptance order
- mem_rdata  input  32  response data

## Operation
- Lock FSM states:
  - IDLE: select data if `data_sram_req`, otherwise inst if `inst_sram_req`.
  - If `mem_req` is asserted and `mem_addr_ok`=0, go to LOCK_D or LOCK_I according to the selected source.
  - LOCK_x: source x stays selected regardless of the other requester. Return to IDLE on the cycle `mem_req && mem_addr_ok`.
- `mem_req` = (selected source req) && !fifo_full && !reset.
- All `mem_*` request fields are muxed from the selected source. With no request they are zero.
- `x_sram_addr_ok` = `mem_req && mem_addr_ok && sel==x`. The non-selected source's addr_ok is 0.
- Owner FIFO:
  - Depth OUTSTANDING, 1 bit per entry (1=data, 0=inst).
  - Push the selected owner on `mem_req && mem_addr_ok`.
  - Pop on `mem_data_ok` when not empty.
  - Count width is $clog2(OUTSTANDING+1). Read and write pointers wrap modulo OUTSTANDING.
- Return steering:
  - `data_sram_data_ok` = `mem_data_ok && !empty && head==1`.
  - `inst_sram_data_ok` = `mem_data_ok && !empty && head==0`.
  - Both rdata outputs equal `mem_rdata`.
- Full FIFO: `mem_req` stays 0 even if a pop happens in the same cycle. The lock state is held.
- Push and pop in the same cycle on a non-full FIFO: count is unchanged and both pointers advance.
- `mem_data_ok` while the FIFO is empty is a protocol error: ignored, no data_ok to either source, count stays 0.
- Writes use the same path. Their `data_ok` is the write completion.
- Pipeline flushes (wb_ex/wb_ertn) do not affect the arbiter. Cancelled requests still receive data_ok, and the stages discard it.

## Timing
- Reset (synchronous): FSM=IDLE, FIFO count=0, pointers=0.
  - During the reset cycle all addr_ok, data_ok and `mem_req` are forced to 0.
  - After reset, outputs are combinational from inputs and state.
- Request path latency is 0 cycles: addr_ok is asserted in the same cycle as `mem_addr_ok`.
- Response path latency is 0 cycles: data_ok is asserted in the same cycle as `mem_data_ok`.
- FIFO and FSM state update on `posedge clk`. A request accepted in cycle N may have its data_ok in cycle N+1 at the earliest. A same-cycle response to a same-cycle request is not supported, because the owner is not yet in the FIFO.
- Throughput is one accepted request per cycle while the FIFO is not full.
- Reset asserted mid-transaction: all outstanding ownership is dropped. The downstream must also be reset in the same cycle.

## Test plan
- Single inst read, addr 0x1c000000: `mem_addr_ok` at cycle 1 → `inst_sram_addr_ok`=1 at cycle 1. `mem_data_ok` with rdata 0x02800413 at cycle 3 → `inst_sram_data_ok`=1, rdata 0x02800413, `data_sram_data_ok`=0.
- Simultaneous inst req and data req (data read, addr 0x1c008000), `mem_addr_ok`=1 → data is granted first and inst the next cycle. Responses 0xAAAA then 0xBBBB → data_ok first, inst_ok second.
- Lock: inst req waits 3 cycles with `mem_addr_ok`=0, then data_req rises → `mem_addr` stays at the inst address until accepted, then data is granted.
- OUTSTANDING=2: three back-to-back accepts are attempted with no responses → third `mem_req`=0 until the first `mem_data_ok`, and it is issued on the following cycle.
- Data write, wstrb 4'b0011, wdata 0x12345678, size 1 → fields pass through unchanged, and `data_sram_data_ok` is asserted on `mem_data_ok`.
- Reset with 2 outstanding, then a spurious `mem_data_ok` → no data_ok to either source, and FIFO count stays 0.
